// File: rtl/op_sequencer.sv
// Five-state operand sequencer: reads two registers, runs a 16-bit ALU op on A and shifted B,
// writes the result back. Outputs are registered and decoded from the next state.
module op_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [1:0]  op,
    input  logic [1:0]  shift,
    input  logic [2:0]  rn,
    input  logic [2:0]  rm,
    input  logic [2:0]  rd,
    input  logic [15:0] rdata,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [15:0] wdata,
    output logic        w,
    output logic        Z,
    output logic        N,
    output logic        V
);

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 3;

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_GETA = 3'd1,
        ST_GETB = 3'd2,
        ST_ALU  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    state_t          state_q, state_d;
    logic [RW-1:0]   rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
    logic [1:0]      op_q, op_d, shift_q, shift_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic            z_q, z_d, n_q, n_d, v_q, v_d;
    logic [RW-1:0]   readnum_q, readnum_d, writenum_q, writenum_d;
    logic            write_q, write_d, w_q, w_d;

    logic [DW-1:0]   b_sh;
    logic [DW-1:0]   alu_res;
    logic            alu_v;

    // B-operand shifter
    always_comb begin
        b_sh = b_q;
        case (shift_q)
            SH_NONE: b_sh = b_q;
            SH_LSL:  b_sh = {b_q[DW-2:0], 1'b0};
            SH_LSR:  b_sh = {1'b0, b_q[DW-1:1]};
            SH_ASR:  b_sh = {b_q[DW-1], b_q[DW-1:1]};
            default: b_sh = b_q;
        endcase
    end

    // ALU with signed-overflow detection for add/sub only
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = DW'(a_q + b_sh);
                alu_v   = (a_q[DW-1] == b_sh[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            OP_SUB: begin
                alu_res = DW'(a_q - b_sh);
                alu_v   = (a_q[DW-1] != b_sh[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            OP_AND:  alu_res = a_q & b_sh;
            OP_NOT:  alu_res = ~b_sh;
            default: alu_res = '0;
        endcase
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d    = state_q;
        rn_d       = rn_q;
        rm_d       = rm_q;
        rd_d       = rd_q;
        op_d       = op_q;
        shift_d    = shift_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        z_d        = z_q;
        n_d        = n_q;
        v_d        = v_q;
        readnum_d  = '0;
        writenum_d = '0;
        write_d    = 1'b0;
        w_d        = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (s) begin
                    rn_d    = rn;
                    rm_d    = rm;
                    rd_d    = rd;
                    op_d    = op;
                    shift_d = shift;
                    state_d = ST_GETA;
                end
            end
            ST_GETA: begin
                a_d     = rdata;
                state_d = ST_GETB;
            end
            ST_GETB: begin
                b_d     = rdata;
                state_d = ST_ALU;
            end
            ST_ALU: begin
                c_d     = alu_res;
                z_d     = (alu_res == '0);
                n_d     = alu_res[DW-1];
                v_d     = alu_v;
                state_d = ST_WB;
            end
            ST_WB:   state_d = ST_WAIT;
            default: state_d = ST_WAIT;
        endcase

        // Outputs for the cycle we are about to enter, so they can be registered
        case (state_d)
            ST_WAIT: w_d = 1'b1;
            ST_GETA: readnum_d = rn_d;
            ST_GETB: readnum_d = rm_d;
            ST_WB: begin
                write_d    = 1'b1;
                writenum_d = rd_d;
            end
            default: w_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_WAIT;
            rn_q       <= '0;
            rm_q       <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            shift_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            v_q        <= 1'b0;
            readnum_q  <= '0;
            writenum_q <= '0;
            write_q    <= 1'b0;
            w_q        <= 1'b1;
        end else begin
            state_q    <= state_d;
            rn_q       <= rn_d;
            rm_q       <= rm_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
            shift_q    <= shift_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            z_q        <= z_d;
            n_q        <= n_d;
            v_q        <= v_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            write_q    <= write_d;
            w_q        <= w_d;
        end
    end

    assign readnum  = readnum_q;
    assign writenum = writenum_q;
    assign write    = write_q;
    assign wdata    = c_q;
    assign w        = w_q;
    assign Z        = z_q;
    assign N        = n_q;
    assign V        = v_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: table of ALU vectors plus hand-written
// back-to-back, ignored-start and mid-operation reset sequences.
module tb_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [1:0]  op, shift;
    logic [2:0]  rn, rm, rd;
    logic [15:0] rdata;
    logic [2:0]  readnum, writenum;
    logic        write, w, Z, N, V;
    logic [15:0] wdata;

    logic [15:0] rf [8];
    logic        pre_en;
    logic [2:0]  pre_idx;
    logic [15:0] pre_val;

    int total = 0;
    int bad   = 0;

    op_sequencer dut (
        .clk(clk), .reset(reset), .s(s), .op(op), .shift(shift),
        .rn(rn), .rm(rm), .rd(rd), .rdata(rdata),
        .readnum(readnum), .writenum(writenum), .write(write),
        .wdata(wdata), .w(w), .Z(Z), .N(N), .V(V)
    );

    always #5 clk = ~clk;

    // Register file model: combinational read, write on rising edge
    assign rdata = rf[readnum];
    always @(posedge clk) begin
        if (pre_en)     rf[pre_idx]  <= pre_val;
        else if (write) rf[writenum] <= wdata;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [2:0]  rd;
        logic [1:0]  op;
        logic [1:0]  sh;
        logic [15:0] exp;
        logic        ez;
        logic        en;
        logic        ev;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        step();
        pre_en  = 1'b0;
    endtask

    task automatic start(input logic [2:0] a_rn, input logic [2:0] a_rm, input logic [2:0] a_rd,
                         input logic [1:0] a_op, input logic [1:0] a_sh);
        rn = a_rn; rm = a_rm; rd = a_rd; op = a_op; shift = a_sh;
        s  = 1'b1;
        step();
        s  = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        preload(v.rn, v.a);
        preload(v.rm, v.b);
        chk($sformatf("v%0d_w_idle", idx), 32'(w), 32'd1);
        start(v.rn, v.rm, v.rd, v.op, v.sh);
        chk($sformatf("v%0d_readnum_a", idx), 32'(readnum), 32'(v.rn));
        step();
        chk($sformatf("v%0d_readnum_b", idx), 32'(readnum), 32'(v.rm));
        cyc = 2;
        while (!write && cyc < 10) begin
            step();
            cyc++;
        end
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'd4);
        chk($sformatf("v%0d_writenum", idx), 32'(writenum), 32'(v.rd));
        chk($sformatf("v%0d_wdata", idx), 32'(wdata), 32'(v.exp));
        chk($sformatf("v%0d_znv", idx), 32'({Z, N, V}), 32'({v.ez, v.en, v.ev}));
        step();
        chk($sformatf("v%0d_w_back", idx), 32'(w), 32'd1);
        chk($sformatf("v%0d_write_off", idx), 32'(write), 32'd0);
        chk($sformatf("v%0d_rf_rd", idx), 32'(rf[v.rd]), 32'(v.exp));
    endtask

    initial begin
        int cyc;
        int seen;
        logic [15:0] exp_acc;

        //          a         b         rn    rm    rd    op     sh     exp       Z     N     V
        vecs[0]  = '{16'h0007, 16'h0003, 3'd0, 3'd1, 3'd2, 2'b00, 2'b00, 16'h000A, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0007, 16'h0003, 3'd0, 3'd1, 3'd2, 2'b01, 2'b01, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h0005, 16'h0005, 3'd0, 3'd1, 3'd2, 2'b01, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h7FFF, 16'h0001, 3'd0, 3'd1, 3'd2, 2'b00, 2'b00, 16'h8000, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{16'h1234, 16'h00FF, 3'd0, 3'd1, 3'd2, 2'b11, 2'b00, 16'hFF00, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{16'h0000, 16'h8004, 3'd0, 3'd1, 3'd2, 2'b11, 2'b11, 16'h3FFD, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'hF0F0, 16'h0FF0, 3'd4, 3'd5, 3'd6, 2'b10, 2'b00, 16'h00F0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h8000, 16'h0001, 3'd0, 3'd1, 3'd2, 2'b01, 2'b00, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{16'h0001, 16'h8004, 3'd0, 3'd1, 3'd2, 2'b00, 2'b10, 16'h4003, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h1111, 16'h1111, 3'd3, 3'd3, 3'd3, 2'b00, 2'b00, 16'h2222, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h0003, 16'h0007, 3'd1, 3'd0, 3'd5, 2'b01, 2'b00, 16'hFFFC, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; s = 1'b0; op = '0; shift = '0; rn = '0; rm = '0; rd = '0;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_w", 32'(w), 32'd1);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_readnum", 32'(readnum), 32'd0);
        chk("rst_writenum", 32'(writenum), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_znv", 32'({Z, N, V}), 32'd0);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Flags and C hold across WAIT
        step();
        step();
        chk("hold_wdata", 32'(wdata), 32'hFFFC);
        chk("hold_znv", 32'({Z, N, V}), 32'b010);

        // s held high: R0 += R1 every 5 cycles
        preload(3'd0, 16'h0001);
        preload(3'd1, 16'h0001);
        exp_acc = 16'h0001;
        start(3'd0, 3'd1, 3'd0, 2'b00, 2'b00);
        s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                step();
                cyc = 1;
            end else begin
                cyc = 1;
            end
            while (!write && cyc < 12) begin
                step();
                cyc++;
            end
            exp_acc = exp_acc + 16'h0001;
            chk($sformatf("b2b%0d_interval", k), 32'(cyc), (k == 0) ? 32'd4 : 32'd5);
            chk($sformatf("b2b%0d_wdata", k), 32'(wdata), 32'(exp_acc));
            if (k == 2) s = 1'b0;
        end
        step();
        step();
        chk("b2b_idle", 32'(w), 32'd1);
        chk("b2b_rf0", 32'(rf[0]), 32'h0004);

        // s pulses while busy are ignored, captured rd kept
        preload(3'd4, 16'h0010);
        preload(3'd5, 16'h0001);
        preload(3'd7, 16'hBEEF);
        start(3'd4, 3'd5, 3'd6, 2'b00, 2'b00);
        s = 1'b1; rd = 3'd7; rn = 3'd1; rm = 3'd1; op = 2'b01;
        step();
        chk("busy_w", 32'(w), 32'd0);
        step();
        step();
        s = 1'b0;
        chk("busy_write", 32'(write), 32'd1);
        chk("busy_writenum", 32'(writenum), 32'd6);
        chk("busy_wdata", 32'(wdata), 32'h0011);
        step();
        chk("busy_rf6", 32'(rf[6]), 32'h0011);
        chk("busy_rf7", 32'(rf[7]), 32'hBEEF);

        // Reset during GETB abandons the operation
        preload(3'd2, 16'h1234);
        preload(3'd3, 16'h1111);
        start(3'd2, 3'd3, 3'd3, 2'b00, 2'b00);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_getb_w", 32'(w), 32'd1);
        chk("rst_getb_write", 32'(write), 32'd0);
        chk("rst_getb_wdata", 32'(wdata), 32'd0);
        chk("rst_getb_znv", 32'({Z, N, V}), 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (write) seen++;
            step();
        end
        chk("rst_getb_nowrite", 32'(seen), 32'd0);
        chk("rst_getb_rf2", 32'(rf[2]), 32'h1234);
        chk("rst_getb_rf3", 32'(rf[3]), 32'h1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
